// File: rtl/pipe_ctrl_unit_if.sv
// Control-unit bus: ID-stage inputs, hazard/redirect outputs and the
// per-stage control bundles. The pipeline (master) drives the ID fields,
// and the control unit (slave) returns stall/jump and the EX/MEM/WB bundles.
interface pipe_ctrl_unit_if #(
    parameter int REG_AW = 5
);
    logic [5:0]        opcode;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              ext_stall;

    logic              stall;
    logic              jump;
    logic              flush_ifid;
    logic              illegal;

    logic              ex_ALUSrc;
    logic [1:0]        ex_ALUOp;
    logic [REG_AW-1:0] ex_dst;

    logic              mem_MemRead;
    logic              mem_MemWrite;
    logic              mem_RegWrite;
    logic [REG_AW-1:0] mem_dst;

    logic              wb_RegWrite;
    logic              wb_MemtoReg;
    logic [REG_AW-1:0] wb_dst;

    modport master (
        output opcode, id_rs, id_rt, id_rd, ext_stall,
        input  stall, jump, flush_ifid, illegal,
        input  ex_ALUSrc, ex_ALUOp, ex_dst,
        input  mem_MemRead, mem_MemWrite, mem_RegWrite, mem_dst,
        input  wb_RegWrite, wb_MemtoReg, wb_dst
    );

    modport slave (
        input  opcode, id_rs, id_rt, id_rd, ext_stall,
        output stall, jump, flush_ifid, illegal,
        output ex_ALUSrc, ex_ALUOp, ex_dst,
        output mem_MemRead, mem_MemWrite, mem_RegWrite, mem_dst,
        output wb_RegWrite, wb_MemtoReg, wb_dst
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: decodes the ID-stage opcode into a control bundle, carries
// it through EX/MEM/WB, inserts load-use bubbles, raises jump/flush and
// freezes everything while the memory system asks for a wait.
module pipe_ctrl_unit #(
    parameter int REG_AW     = 5,
    parameter int LU_STALL   = 1,
    parameter int JUMP_FLUSH = 1
) (
    input  logic            clk,
    input  logic            reset,
    pipe_ctrl_unit_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_NOP   = 6'b111100;

    // Counter reload: the hazard cycle itself is the first bubble.
    localparam logic [1:0] LU_RELOAD = 2'(LU_STALL - 1);

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic [1:0]        alu_op;
        logic [REG_AW-1:0] dst;
    } ctrl_t;

    ctrl_t             dec_c;
    logic              dec_illegal;
    ctrl_t             ex_q;
    ctrl_t             ex_d;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              mem_reg_write_q;
    logic              mem_to_reg_q;
    logic [REG_AW-1:0] mem_dst_q;
    logic              wb_reg_write_q;
    logic              wb_to_reg_q;
    logic [REG_AW-1:0] wb_dst_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic              uses_rt;
    logic              hazard;
    logic              bubble;
    logic              accept;

    // Opcode decode; unknown opcodes collapse to a NOP bundle and flag illegal.
    always_comb begin
        dec_c       = '0;
        dec_illegal = 1'b0;
        case (bus.opcode)
            OP_LW: begin
                dec_c.mem_read   = 1'b1;
                dec_c.alu_src    = 1'b1;
                dec_c.mem_to_reg = 1'b1;
                dec_c.reg_write  = 1'b1;
                dec_c.dst        = bus.id_rt;
            end
            OP_SW: begin
                dec_c.mem_write = 1'b1;
                dec_c.alu_src   = 1'b1;
            end
            OP_RTYPE: begin
                dec_c.alu_op    = 2'b10;
                dec_c.reg_write = 1'b1;
                dec_c.dst       = bus.id_rd;
            end
            OP_ANDI: begin
                dec_c.alu_src   = 1'b1;
                dec_c.alu_op    = 2'b11;
                dec_c.reg_write = 1'b1;
                dec_c.dst       = bus.id_rt;
            end
            OP_J, OP_NOP: ;
            default: dec_illegal = 1'b1;
        endcase
        // Register 0 is hard-wired, so a write to it is dropped at decode.
        if (dec_c.dst == '0) begin
            dec_c.reg_write = 1'b0;
        end
    end

    // Load-use detection and stall-counter next state.
    always_comb begin
        uses_rt = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_SW);
        hazard  = ex_q.mem_read && (ex_q.dst != '0) &&
                  ((ex_q.dst == bus.id_rs) || (uses_rt && (ex_q.dst == bus.id_rt)));
        bubble  = hazard || (cnt_q != 2'd0);
        accept  = !reset && !bus.ext_stall && !bubble;
        ex_d    = bubble ? ctrl_t'('0) : dec_c;
        cnt_d   = 2'd0;
        if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end else if (hazard) begin
            cnt_d = LU_RELOAD;
        end
    end

    // Stage registers: advance one stage per clock unless frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q            <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_reg_write_q <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            mem_dst_q       <= '0;
            wb_reg_write_q  <= 1'b0;
            wb_to_reg_q     <= 1'b0;
            wb_dst_q        <= '0;
            cnt_q           <= 2'd0;
        end else if (!bus.ext_stall) begin
            ex_q            <= ex_d;
            mem_read_q      <= ex_q.mem_read;
            mem_write_q     <= ex_q.mem_write;
            mem_reg_write_q <= ex_q.reg_write;
            mem_to_reg_q    <= ex_q.mem_to_reg;
            mem_dst_q       <= ex_q.dst;
            wb_reg_write_q  <= mem_reg_write_q;
            wb_to_reg_q     <= mem_to_reg_q;
            wb_dst_q        <= mem_dst_q;
            cnt_q           <= cnt_d;
        end
    end

    assign bus.stall        = !reset && (bus.ext_stall || bubble);
    assign bus.jump         = accept && (bus.opcode == OP_J);
    assign bus.flush_ifid   = (JUMP_FLUSH != 0) && bus.jump;
    assign bus.illegal      = accept && dec_illegal;

    assign bus.ex_ALUSrc    = ex_q.alu_src;
    assign bus.ex_ALUOp     = ex_q.alu_op;
    assign bus.ex_dst       = ex_q.dst;
    assign bus.mem_MemRead  = mem_read_q;
    assign bus.mem_MemWrite = mem_write_q;
    assign bus.mem_RegWrite = mem_reg_write_q;
    assign bus.mem_dst      = mem_dst_q;
    assign bus.wb_RegWrite  = wb_reg_write_q;
    assign bus.wb_MemtoReg  = wb_to_reg_q;
    assign bus.wb_dst       = wb_dst_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (LU_STALL=1/JUMP_FLUSH=1 and
// LU_STALL=3/JUMP_FLUSH=0) share one directed input stream. Expected bundles
// are queued per instance as they enter EX and compared at EX/MEM/WB.
module tb_pipe_ctrl_unit;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_NOP  = 6'b111100;
    localparam logic [5:0] OP_ILL  = 6'b011111;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [4:0] dst;
    } bnd_t;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       ext_stall;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int step_no   = 0;

    bnd_t qa[$];
    bnd_t qb[$];

    pipe_ctrl_unit_if #(.REG_AW(5)) bus_a ();
    pipe_ctrl_unit_if #(.REG_AW(5)) bus_b ();

    assign bus_a.opcode    = opcode;
    assign bus_a.id_rs     = id_rs;
    assign bus_a.id_rt     = id_rt;
    assign bus_a.id_rd     = id_rd;
    assign bus_a.ext_stall = ext_stall;
    assign bus_b.opcode    = opcode;
    assign bus_b.id_rs     = id_rs;
    assign bus_b.id_rt     = id_rt;
    assign bus_b.id_rd     = id_rd;
    assign bus_b.ext_stall = ext_stall;

    pipe_ctrl_unit #(.REG_AW(5), .LU_STALL(1), .JUMP_FLUSH(1)) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_a)
    );

    pipe_ctrl_unit #(.REG_AW(5), .LU_STALL(3), .JUMP_FLUSH(0)) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_b)
    );

    logic [3:0] ctl_a, ctl_b;
    logic [7:0] ex_a, ex_b, mem_a, mem_b;
    logic [6:0] wb_a, wb_b;
    assign ctl_a = {bus_a.stall, bus_a.jump, bus_a.flush_ifid, bus_a.illegal};
    assign ctl_b = {bus_b.stall, bus_b.jump, bus_b.flush_ifid, bus_b.illegal};
    assign ex_a  = {bus_a.ex_ALUSrc, bus_a.ex_ALUOp, bus_a.ex_dst};
    assign ex_b  = {bus_b.ex_ALUSrc, bus_b.ex_ALUOp, bus_b.ex_dst};
    assign mem_a = {bus_a.mem_MemRead, bus_a.mem_MemWrite, bus_a.mem_RegWrite, bus_a.mem_dst};
    assign mem_b = {bus_b.mem_MemRead, bus_b.mem_MemWrite, bus_b.mem_RegWrite, bus_b.mem_dst};
    assign wb_a  = {bus_a.wb_RegWrite, bus_a.wb_MemtoReg, bus_a.wb_dst};
    assign wb_b  = {bus_b.wb_RegWrite, bus_b.wb_MemtoReg, bus_b.wb_dst};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected bundle for an accepted instruction, straight from the decode table.
    function automatic bnd_t decode(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
        bnd_t b;
        b = '0;
        case (op)
            OP_LW:   begin b.mem_read = 1; b.alu_src = 1; b.mem_to_reg = 1; b.reg_write = 1; b.dst = rt; end
            OP_SW:   begin b.mem_write = 1; b.alu_src = 1; end
            OP_RT:   begin b.alu_op = 2'b10; b.reg_write = 1; b.dst = rd; end
            OP_ANDI: begin b.alu_src = 1; b.alu_op = 2'b11; b.reg_write = 1; b.dst = rt; end
            default: b = '0;
        endcase
        if (b.dst == 5'd0) b.reg_write = 1'b0;
        return b;
    endfunction

    function automatic logic is_illegal(input logic [5:0] op);
        return !(op == OP_LW || op == OP_SW || op == OP_RT || op == OP_ANDI ||
                 op == OP_J  || op == OP_NOP);
    endfunction

    // {stall, jump, flush_ifid, illegal} given freeze, expected load-use bubble, flush mode.
    function automatic logic [3:0] exp_ctl(input logic [5:0] op, input logic ext,
                                           input logic lu, input logic jf);
        logic adv;
        logic jmp;
        adv = !ext && !lu;
        jmp = adv && (op == OP_J);
        return {ext | lu, jmp, jf & jmp, adv & is_illegal(op)};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dut_check(input string nm, input logic [3:0] c_o, input logic [3:0] c_e,
                             input logic [7:0] e_o, input logic [7:0] m_o, input logic [6:0] w_o,
                             input bnd_t e_ex, input bnd_t e_mem, input bnd_t e_wb);
        chk($sformatf("s%0d_%s_ctl", step_no, nm), 12'(c_o), 12'(c_e));
        chk($sformatf("s%0d_%s_ex", step_no, nm), 12'(e_o),
            12'({e_ex.alu_src, e_ex.alu_op, e_ex.dst}));
        chk($sformatf("s%0d_%s_mem", step_no, nm), 12'(m_o),
            12'({e_mem.mem_read, e_mem.mem_write, e_mem.reg_write, e_mem.dst}));
        chk($sformatf("s%0d_%s_wb", step_no, nm), 12'(w_o),
            12'({e_wb.reg_write, e_wb.mem_to_reg, e_wb.dst}));
    endtask

    // One clock: drive ID inputs, check both instances, then advance the scoreboards.
    task automatic step(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic ext, input logic sa, input logic sb);
        bnd_t na;
        bnd_t nb;
        opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; ext_stall = ext;
        #1;
        dut_check("A", ctl_a, exp_ctl(op, ext, sa, 1'b1), ex_a, mem_a, wb_a, qa[2], qa[1], qa[0]);
        dut_check("B", ctl_b, exp_ctl(op, ext, sb, 1'b0), ex_b, mem_b, wb_b, qb[2], qb[1], qb[0]);
        $display("step %0d op=%b rs=%0d rt=%0d rd=%0d ext=%0b ctlA=%b ctlB=%b wbA=%h wbB=%h",
                 step_no, op, rs, rt, rd, ext, ctl_a, ctl_b, wb_a, wb_b);
        na = sa ? bnd_t'('0) : decode(op, rt, rd);
        nb = sb ? bnd_t'('0) : decode(op, rt, rd);
        @(posedge clk);
        if (!ext) begin
            qa.push_back(na); void'(qa.pop_front());
            qb.push_back(nb); void'(qb.pop_front());
        end
        @(negedge clk);
        step_no++;
    endtask

    // One reset clock with distracting inputs; control outputs must stay low.
    task automatic reset_cycle(input logic [5:0] op, input logic [4:0] rs, input logic ext);
        rst = 1'b1; opcode = op; id_rs = rs; id_rt = 5'd0; id_rd = 5'd3; ext_stall = ext;
        #1;
        chk($sformatf("s%0d_A_rst_ctl", step_no), 12'(ctl_a), 12'd0);
        chk($sformatf("s%0d_B_rst_ctl", step_no), 12'(ctl_b), 12'd0);
        $display("step %0d reset op=%b ext=%0b ctlA=%b ctlB=%b", step_no, op, ext, ctl_a, ctl_b);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        qa.delete(); qb.delete();
        repeat (3) begin qa.push_back('0); qb.push_back('0); end
        step_no++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; opcode = OP_NOP; id_rs = 0; id_rt = 0; id_rd = 0; ext_stall = 1'b0;
        @(negedge clk);
        reset_cycle(OP_J, 5'd0, 1'b1);
        reset_cycle(OP_J, 5'd0, 1'b1);

        // lw r5 then dependent R-type: A stalls once, B three times
        step(OP_LW,  5'd0, 5'd5, 5'd0, 0, 0, 0);
        step(OP_RT,  5'd5, 5'd2, 5'd7, 0, 1, 1);
        step(OP_RT,  5'd5, 5'd2, 5'd7, 0, 0, 1);
        step(OP_RT,  5'd5, 5'd2, 5'd7, 0, 0, 1);
        step(OP_RT,  5'd5, 5'd2, 5'd7, 0, 0, 0);
        repeat (3) step(OP_NOP, 5'd0, 5'd0, 5'd0, 0, 0, 0);

        // lw to r0 never creates a hazard and never writes back
        step(OP_LW,  5'd0, 5'd0, 5'd0, 0, 0, 0);
        step(OP_RT,  5'd0, 5'd3, 5'd4, 0, 0, 0);

        // jump: A flushes, B keeps its delay slot
        step(OP_J,   5'd0, 5'd0, 5'd0, 0, 0, 0);

        // andi/sw, and rt only counts for R-type/sw
        step(OP_ANDI, 5'd0, 5'd6, 5'd0, 0, 0, 0);
        step(OP_SW,   5'd6, 5'd7, 5'd0, 0, 0, 0);
        step(OP_LW,   5'd0, 5'd5, 5'd0, 0, 0, 0);
        step(OP_ANDI, 5'd0, 5'd5, 5'd0, 0, 0, 0);
        step(OP_LW,   5'd0, 5'd5, 5'd0, 0, 0, 0);
        step(OP_SW,   5'd0, 5'd5, 5'd0, 0, 1, 1);
        step(OP_SW,   5'd0, 5'd5, 5'd0, 0, 0, 1);
        step(OP_SW,   5'd0, 5'd5, 5'd0, 0, 0, 1);
        step(OP_NOP,  5'd0, 5'd0, 5'd0, 0, 0, 0);

        // freeze over a pending hazard, then freeze again mid-count
        step(OP_LW,  5'd0, 5'd9, 5'd0, 0, 0, 0);
        repeat (4) step(OP_RT, 5'd9, 5'd1, 5'd2, 1, 1, 1);
        step(OP_RT,  5'd9, 5'd1, 5'd2, 0, 1, 1);
        repeat (2) step(OP_RT, 5'd9, 5'd1, 5'd2, 1, 1, 1);
        step(OP_RT,  5'd9, 5'd1, 5'd2, 0, 0, 1);
        step(OP_RT,  5'd9, 5'd1, 5'd2, 0, 0, 1);
        step(OP_RT,  5'd9, 5'd1, 5'd2, 0, 0, 0);
        repeat (3) step(OP_NOP, 5'd0, 5'd0, 5'd0, 0, 0, 0);

        // undecoded opcode: suppressed while frozen, one pulse when accepted
        step(OP_ILL, 5'd0, 5'd4, 5'd4, 1, 0, 0);
        step(OP_ILL, 5'd0, 5'd4, 5'd4, 0, 0, 0);
        repeat (3) step(OP_NOP, 5'd0, 5'd0, 5'd0, 0, 0, 0);

        // reset in the middle of a load-use stall
        step(OP_LW,  5'd0, 5'd8, 5'd0, 0, 0, 0);
        step(OP_RT,  5'd8, 5'd0, 5'd3, 0, 1, 1);
        reset_cycle(OP_RT, 5'd8, 1'b1);
        step(OP_RT,  5'd8, 5'd0, 5'd3, 0, 0, 0);
        repeat (3) step(OP_NOP, 5'd0, 5'd0, 5'd0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter: REG_AW, default 5, register-address width.
REQ-002 Parameter: LU_STALL, default 1, legal 1..3; number of bubble cycles inserted per load-use hazard.
REQ-003 Parameter: JUMP_FLUSH, default 1; 1 = flush IF/ID on a taken jump, 0 = no flush (delay slot executes).
REQ-004 clk  in  1  rising-edge clock; the only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 opcode  in  6  ID-stage instruction opcode.
REQ-007 id_rs, id_rt, id_rd  in  REG_AW each  ID-stage register fields.
REQ-008 ext_stall  in  1  memory-wait freeze request.
REQ-009 stall  out  1  hold PC and IF/ID this cycle.
REQ-010 jump  out  1  redirect PC to jump target this cycle.
REQ-011 flush_ifid  out  1  load NOP into IF/ID at next edge.
REQ-012 illegal  out  1  one-cycle pulse: undecoded opcode accepted from ID.
REQ-013 ex_ALUSrc  out  1;  ex_ALUOp  out  2;  ex_dst  out  REG_AW  EX-stage control bundle.
REQ-014 mem_MemRead, mem_MemWrite, mem_RegWrite  out  1 each;  mem_dst  out  REG_AW  MEM-stage bundle.
REQ-015 wb_RegWrite, wb_MemtoReg  out  1 each;  wb_dst  out  REG_AW  WB-stage bundle.

Function
REQ-016 Decode: lw 100011 -> MemRead, ALUSrc, ALUOp 00, MemtoReg, RegWrite, dst=rt.
REQ-017 Decode: sw 101011 -> MemWrite, ALUSrc, ALUOp 00; no RegWrite.
REQ-018 Decode: R-type 000000 -> ALUOp 10, RegWrite, dst=rd.
REQ-019 Decode: andi 001100 -> ALUSrc, ALUOp 11, RegWrite, dst=rt.
REQ-020 Decode: j 000010 -> jump only; enters EX as bubble.
REQ-021 Decode: 111100 -> NOP; any other opcode -> NOP bundle plus illegal pulse; no signal ever x.
REQ-022 Bubble = all control bits 0, dst 0.
REQ-023 Any RegWrite with dst 0 is carried as RegWrite 0.
REQ-024 Bundles advance ID->EX->MEM->WB one stage per clk; decode-to-wb_RegWrite latency 3 edges.
REQ-025 Load-use hazard: EX holds lw, ex_dst != 0, and (ex_dst == id_rs, or ex_dst == id_rt for R-type/sw).
REQ-026 On hazard: stall=1 and a bubble enters EX for exactly LU_STALL consecutive cycles.
REQ-027 The down-counter loads LU_STALL-1 on hazard; stall stays 1 while count != 0.
REQ-028 ID bundle enters EX on the first cycle with stall=0.
REQ-029 jump = (opcode==j) & ~stall, combinational.
REQ-030 flush_ifid = jump when JUMP_FLUSH=1, else 0.
REQ-031 ext_stall=1: all bundles and stall counter hold; stall=1; jump, flush_ifid, illegal = 0.
REQ-032 ext_stall has priority over hazard and jump; a hazard pending under ext_stall is evaluated after release.
REQ-033 illegal pulses only in the cycle the undecoded opcode advances to EX.

Reset
REQ-034 While reset=1 at a clk edge: all bundles cleared to bubble, counter = 0.
REQ-035 After reset: stall, jump, flush_ifid, illegal = 0, regardless of ext_stall or opcode that cycle.
REQ-036 Reset mid-stall aborts the stall; no bubble or ID bundle survives reset.

Verification
REQ-037 lw rt=5 then R-type rs=5, LU_STALL=1 -> stall=1 one cycle, one bubble; R-type reaches wb with wb_dst=rd.
REQ-038 Same sequence, LU_STALL=3 -> stall=1 three consecutive cycles, three bubbles in WB order.
REQ-039 lw rt=0 then R-type rs=0 -> no stall; wb_RegWrite=0 for lw.
REQ-040 j with JUMP_FLUSH=1 -> jump=1, flush_ifid=1 same cycle; EX receives bubble.
REQ-041 j with JUMP_FLUSH=0 -> jump=1, flush_ifid=0 same cycle.
REQ-042 ext_stall high 4 cycles during hazard -> bundles frozen; stall count resumes after release.
REQ-043 Opcode 011111 -> illegal pulse 1 cycle; all bundle bits 0 downstream.
REQ-044 reset asserted mid-hazard -> next cycle stall=0, all outputs 0.
